instr_prefetch_queue: RTL and testbench

- Fetch front-end that sits directly upstream of the CPU decode stage.
- Autonomously issues sequential reads to instruction memory and buffers the returned 8-bit instructions, each with its PC, in a small FIFO.
- The CPU pops with a valid/ready handshake and redirects the fetch stream on jump/branch/jal, which flushes the queue.

---
 rtl/instr_prefetch_queue_pkg.sv | 34 +++
 rtl/instr_prefetch_queue_fifo.sv | 98 +++++++++
 rtl/instr_prefetch_queue.sv | 159 +++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM state encoding,
// the halt opcode, the control-flow opcodes the CPU decodes to drive redirect,
// default geometry and a pointer-width helper.
// Optional feature macro: PFQ_HALT_STOP_EN (halt-instruction fetch stop).
package instr_prefetch_queue_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } pfq_state_e;

    // Instruction that stops fetching when PFQ_HALT_STOP_EN is defined
    localparam logic [7:0] HALT_INSTR = 8'h00;

    // Control-flow opcodes (upper nibble of an instruction). The CPU decodes
    // these and answers with redirect/redirect_pc; the queue never decodes them.
    localparam logic [3:0] OPC_J   = 4'h1;
    localparam logic [3:0] OPC_JAL = 4'h2;
    localparam logic [3:0] OPC_BEQ = 4'h3;
    localparam logic [3:0] OPC_BNE = 4'h4;

    // Default geometry
    localparam int PFQ_DEPTH  = 4;
    localparam int PFQ_ADDR_W = 8;
    localparam int PFQ_DATA_W = 8;

    // Pointer width for a power-of-two FIFO depth (at least one bit)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// pfq_fifo: DEPTH-entry circular buffer holding {instruction, pc} entries.
// Flush has priority over push and pop. The head entry and its valid flag are
// registered so the consumer sees flop outputs; the head reads as zero when
// the queue is empty.
module pfq_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = PFQ_DEPTH,
    parameter int WIDTH = PFQ_DATA_W + PFQ_ADDR_W,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             do_push, do_pop, full;

    // Next-state for storage, pointers, occupancy and the registered head
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        full    = (count_q == CNT_W'(DEPTH));
        do_pop  = pop && (count_q != '0);
        do_push = push && (!full || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Looking at next-cycle storage lets a push into an empty queue
        // appear at the head one cycle later without a separate bypass.
        head_valid_d = (count_d != '0);
        head_data_d  = head_valid_d ? mem_d[rd_ptr_d] : '0;
    end

    // Entry storage
    // NOTE: storage is deliberately not reset; the head is forced to zero while empty, so unwritten entries are never observable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointers, occupancy and head registers with synchronous reset
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;
    assign count      = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch front-end ahead of decode. Issues sequential
// instruction-memory reads while credit allows, buffers {instruction, pc} in
// pfq_fifo, and restarts the stream on redirect (flushing the queue and
// discarding the old stream's trailing response).
// Optional feature macro: PFQ_HALT_STOP_EN -- enqueuing HALT_INSTR stops
// fetching and raises halted until the next redirect.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH  = PFQ_DEPTH,
    parameter int ADDR_W = PFQ_ADDR_W,
    parameter int DATA_W = PFQ_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int PTR_W   = ptr_width(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    pfq_state_e        state_q, state_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;        // response due this cycle
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;  // PC of that response
    logic              drop_q, drop_d;                // old-stream response window
    logic              halted_q, halted_d;

    logic              fifo_head_valid;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop, resp_ok, push, halt_hit, credit_ok;
    logic [OCC_W-1:0]  occupancy;

    // Handshakes, response acceptance and request credit
    always_comb begin
        pop     = fifo_head_valid && instr_ready;
        resp_ok = imem_valid && inflight_q && !drop_q;
        push    = resp_ok && !redirect;
        // Entries already queued, plus the response arriving now, plus the
        // request on the bus this cycle: all of them will need a slot.
        occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) + OCC_W'(imem_req_q);
        credit_ok = (occupancy < OCC_W'(DEPTH));
`ifdef PFQ_HALT_STOP_EN
        halt_hit = push && (imem_data == DATA_W'(HALT_INSTR));
`else
        halt_hit = 1'b0;
`endif
    end

    // Fetch FSM next state, request generation and redirect handling
    always_comb begin
        state_d       = state_q;
        imem_req_d    = 1'b0;
        imem_addr_d   = imem_addr_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req_q;
        inflight_pc_d = imem_addr_q;
        drop_d        = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (halt_hit) begin
                    state_d = HALTED;
                end else if (credit_ok) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
                end
            end
            HALTED: begin
                // No requests; a response already in flight still enqueues.
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything above; the request on the bus now
        // answers next cycle and belongs to the old stream, so it is dropped.
        if (redirect) begin
            state_d    = FETCH;
            imem_req_d = 1'b0;
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            drop_d     = 1'b1;
        end

`ifdef PFQ_HALT_STOP_EN
        halted_d = (state_d == HALTED);
`else
        halted_d = 1'b0;
`endif
    end

    // FSM and registered fetch-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            drop_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
        end
    end

    pfq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_data  ({imem_data, inflight_pc_q}),
        .pop        (pop),
        .head_valid (fifo_head_valid),
        .head_data  (fifo_head),
        .count      (fifo_count)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = fifo_head_valid;
    assign instr_data  = fifo_head[ENTRY_W-1 -: DATA_W];
    assign instr_pc    = fifo_head[ADDR_W-1:0];
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed testbench for instr_prefetch_queue. Memory returns addr+8'h10,
// except that in the halt scenario address 8'h03 returns the halt opcode.
// Expectations for the halt scenario follow PFQ_HALT_STOP_EN.
module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       instr_ready = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halted;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic halt_mode = 1'b0;

    logic [15:0] pop_log [$];
    logic [7:0]  req_log [$];
    int          pop_cyc [$];

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        imem_valid <= imem_req;
        imem_data  <= (halt_mode && imem_addr == 8'h03) ? HALT_INSTR : imem_addr + 8'h10;
    end

    // Record issued request addresses and accepted pops
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (imem_req) req_log.push_back(imem_addr);
            if (instr_valid && instr_ready && !redirect) begin
                pop_log.push_back({instr_pc, instr_data});
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no summary expected summary");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] pop_at(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 16'hxxxx;
    endfunction

    function automatic logic [7:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < pop_cyc.size()) return pop_cyc[i];
        return -1000;
    endfunction

    task automatic clear_logs();
        pop_log.delete();
        req_log.delete();
        pop_cyc.delete();
    endtask

    task automatic apply_reset(input logic ready);
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        instr_ready = ready;
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_imem_addr: got %h expected 00", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (instr_data !== 8'h00) begin failures++; $display("FAIL reset_instr_data: got %h expected 00", instr_data); end
        checks++; if (instr_pc !== 8'h00) begin failures++; $display("FAIL reset_instr_pc: got %h expected 00", instr_pc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
        clear_logs();
        rst_n = 1'b1;
    endtask

    // Startup latency and one instruction per cycle with ready held high
    task automatic test_free_run();
        logic [7:0] pc_v;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL startup_idle_req: got %b expected 0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL startup_first_req: got req=%b addr=%h expected req=1 addr=00", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL startup_valid_early: got %b expected 0", instr_valid); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_data !== 8'h10) begin failures++; $display("FAIL startup_first_instr: got v=%b pc=%h d=%h expected v=1 pc=00 d=10", instr_valid, instr_pc, instr_data); end
        repeat (16) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            pc_v = 8'(i);
            checks++; if (req_at(i) !== pc_v) begin failures++; $display("FAIL free_run_addr[%0d]: got %h expected %h", i, req_at(i), pc_v); end
            checks++; if (pop_at(i) !== {pc_v, pc_v + 8'h10}) begin failures++; $display("FAIL free_run_pop[%0d]: got %h expected %h", i, pop_at(i), {pc_v, pc_v + 8'h10}); end
        end
        checks++; if (cyc_at(11) - cyc_at(0) !== 11) begin failures++; $display("FAIL free_run_throughput: got %0d cycles for 12 pops expected 11", cyc_at(11) - cyc_at(0)); end
    endtask

    // Stalled consumer: credit limits outstanding work to DEPTH entries
    task automatic test_backpressure();
        logic [7:0] pc_v;
        apply_reset(1'b0);
        repeat (20) @(negedge clk);
        checks++; if (req_log.size() !== 4) begin failures++; $display("FAIL stall_req_count: got %0d expected 4", req_log.size()); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req_low: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_data !== 8'h10) begin failures++; $display("FAIL stall_head_hold: got v=%b pc=%h d=%h expected v=1 pc=00 d=10", instr_valid, instr_pc, instr_data); end
        checks++; if (pop_log.size() !== 0) begin failures++; $display("FAIL stall_no_pop: got %0d pops expected 0", pop_log.size()); end
        instr_ready = 1'b1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pc_v = 8'(i);
            checks++; if (pop_at(i) !== {pc_v, pc_v + 8'h10}) begin failures++; $display("FAIL drain_pop[%0d]: got %h expected %h", i, pop_at(i), {pc_v, pc_v + 8'h10}); end
        end
        checks++; if (cyc_at(3) - cyc_at(0) !== 3) begin failures++; $display("FAIL drain_back_to_back: got %0d cycles expected 3", cyc_at(3) - cyc_at(0)); end
        checks++; if (req_at(4) !== 8'h04) begin failures++; $display("FAIL drain_req_resume: got %h expected 04", req_at(4)); end
    endtask

    // Redirect with entries queued, a response arriving and a request outstanding
    task automatic test_redirect();
        int snap_req, snap_pop;
        apply_reset(1'b0);
        repeat (20) @(negedge clk);
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h03) begin failures++; $display("FAIL redirect_setup_head: got v=%b pc=%h expected v=1 pc=03", instr_valid, instr_pc); end
        redirect = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush: got instr_valid=%b expected 0", instr_valid); end
        snap_req = req_log.size();
        snap_pop = pop_log.size();
        instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (req_at(snap_req) !== 8'h40) begin failures++; $display("FAIL redirect_first_addr: got %h expected 40", req_at(snap_req)); end
        checks++; if (pop_at(snap_pop) !== 16'h4050) begin failures++; $display("FAIL redirect_first_pop: got %h expected 4050", pop_at(snap_pop)); end
        checks++; if (pop_at(snap_pop + 1) !== 16'h4151) begin failures++; $display("FAIL redirect_second_pop: got %h expected 4151", pop_at(snap_pop + 1)); end
    endtask

    // Redirect in the same cycle as a pop, to a target that wraps the PC
    task automatic test_wrap_redirect_pop();
        int snap_req, snap_pop;
        logic [7:0] exp_pc [4];
        exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL wrap_setup_valid: got %b expected 1", instr_valid); end
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_redirect_wins: got instr_valid=%b expected 0", instr_valid); end
        snap_req = req_log.size();
        snap_pop = pop_log.size();
        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_at(snap_req + i) !== exp_pc[i]) begin failures++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, req_at(snap_req + i), exp_pc[i]); end
            checks++; if (pop_at(snap_pop + i) !== {exp_pc[i], exp_pc[i] + 8'h10}) begin failures++; $display("FAIL wrap_pop[%0d]: got %h expected %h", i, pop_at(snap_pop + i), {exp_pc[i], exp_pc[i] + 8'h10}); end
        end
    endtask

    // Reset (with redirect also asserted) while a read is outstanding
    task automatic test_reset_midflight();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL midreset_setup_req: got %b expected 1", imem_req); end
        rst_n = 1'b0;
        redirect = 1'b1;
        redirect_pc = 8'h80;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h00) begin failures++; $display("FAIL midreset_req: got req=%b addr=%h expected req=0 addr=00", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0 || instr_pc !== 8'h00 || instr_data !== 8'h00) begin failures++; $display("FAIL midreset_head: got v=%b pc=%h d=%h expected all 0", instr_valid, instr_pc, instr_data); end
        rst_n = 1'b1;
        redirect = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL midreset_stale_resp: got instr_valid=%b expected 0", instr_valid); end
        repeat (8) @(negedge clk);
        checks++; if (req_at(0) !== 8'h00) begin failures++; $display("FAIL midreset_first_addr: got %h expected 00", req_at(0)); end
        checks++; if (pop_at(0) !== 16'h0010) begin failures++; $display("FAIL midreset_first_pop: got %h expected 0010", pop_at(0)); end
    endtask

    // Halt opcode at address 3
    task automatic test_halt();
        int snap_req;
        logic [7:0] pc_v;
        halt_mode = 1'b1;
        apply_reset(1'b1);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pc_v = 8'(i);
            checks++; if (pop_at(i) !== {pc_v, pc_v + 8'h10}) begin failures++; $display("FAIL halt_pop[%0d]: got %h expected %h", i, pop_at(i), {pc_v, pc_v + 8'h10}); end
        end
        checks++; if (pop_at(3) !== 16'h0300) begin failures++; $display("FAIL halt_pop[3]: got %h expected 0300", pop_at(3)); end
`ifdef PFQ_HALT_STOP_EN
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b expected 1", halted); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL halt_req_stopped: got %b expected 0", imem_req); end
        checks++; if (req_log.size() < 4 || req_log.size() > 5) begin failures++; $display("FAIL halt_req_count: got %0d expected 4 or 5", req_log.size()); end
`else
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_flag_off: got %b expected 0", halted); end
        checks++; if (req_log.size() <= 8) begin failures++; $display("FAIL halt_off_fetch_continues: got %0d requests expected more than 8", req_log.size()); end
        checks++; if (pop_at(4) !== 16'h0414) begin failures++; $display("FAIL halt_off_pop[4]: got %h expected 0414", pop_at(4)); end
`endif
        redirect = 1'b1;
        redirect_pc = 8'h00;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_cleared_by_redirect: got %b expected 0", halted); end
        snap_req = req_log.size();
        repeat (4) @(negedge clk);
        checks++; if (req_at(snap_req) !== 8'h00) begin failures++; $display("FAIL halt_restart_addr: got %h expected 00", req_at(snap_req)); end
        halt_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_wrap_redirect_pop();
        test_reset_midflight();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
